// File: rtl/pwm_generator_pkg.sv
// Shared sizing helpers and default parameter values for the PWM generator.
// Pure constants; no logic, no latency.
package pwm_generator_pkg;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_PERIOD          = 10;
    localparam int DEF_DUTY_INIT       = 5;
    localparam int DEF_DUTY_STEP       = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    localparam int DUTY_W = cnt_width(DEF_PERIOD + 1);

endpackage

// File: rtl/pwm_generator_if.sv
// Button inputs, debounced levels and PWM output of the generator.
// Wires only; no latency, no backpressure.
interface pwm_generator_if;
    logic increase_duty;
    logic decrease_duty;
    logic inc_level;
    logic dec_level;
    logic out;

    modport master (
        output increase_duty, decrease_duty,
        input  inc_level, dec_level, out
    );

    modport slave (
        input  increase_duty, decrease_duty,
        output inc_level, dec_level, out
    );
endinterface

// File: rtl/pwm_generator_button_debounce.sv
// Synchronise, debounce and edge-detect one asynchronous button.
// Latency 2 + DEBOUNCE_CYCLES cycles from pin to rise_pulse; no backpressure.
module button_debounce
    import pwm_generator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic rise_pulse
);
    localparam int SW = cnt_width(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [SW-1:0] stable_cnt;
    logic          btn_sync;

    assign btn_sync = sync_q[1];

    // The pulse is raised on the same edge the debounced level flips to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            stable_cnt <= '0;
            btn_level  <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_in};
            rise_pulse <= 1'b0;
            if (btn_sync != btn_level) begin
                if (stable_cnt == SW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_level  <= btn_sync;
                    stable_cnt <= '0;
                    rise_pulse <= btn_sync;
                end else begin
                    stable_cnt <= stable_cnt + SW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// Fixed-period PWM with button-stepped, saturating duty applied only at period boundaries.
// Output registered one cycle behind the period counter; no backpressure.
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter int PERIOD          = DEF_PERIOD,
    parameter int DUTY_INIT       = DEF_DUTY_INIT,
    parameter int DUTY_STEP       = DEF_DUTY_STEP,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    pwm_generator_if.slave  pwm
);
    localparam int DW = cnt_width(PERIOD + 1);
    localparam int CW = cnt_width(PERIOD);

    logic          inc_pulse;
    logic          dec_pulse;
    logic [CW-1:0] cnt;
    logic [DW-1:0] duty_req;
    logic [DW-1:0] duty_act;
    logic [DW:0]   inc_sum;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (pwm.increase_duty),
        .btn_level  (pwm.inc_level),
        .rise_pulse (inc_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_btn (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (pwm.decrease_duty),
        .btn_level  (pwm.dec_level),
        .rise_pulse (dec_pulse)
    );

    // One extra bit so the saturation test cannot wrap.
    assign inc_sum = {1'b0, duty_req} + (DW+1)'(DUTY_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            duty_req <= DW'(DUTY_INIT);
            duty_act <= DW'(DUTY_INIT);
            pwm.out  <= 1'b0;
        end else begin
            cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);

            if (inc_pulse && !dec_pulse) begin
                duty_req <= (inc_sum > (DW+1)'(PERIOD)) ? DW'(PERIOD) : inc_sum[DW-1:0];
            end else if (dec_pulse && !inc_pulse) begin
                duty_req <= (duty_req < DW'(DUTY_STEP)) ? '0 : duty_req - DW'(DUTY_STEP);
            end

            // Latching only on the last count keeps every period whole.
            if (cnt == CW'(PERIOD - 1)) begin
                duty_act <= duty_req;
            end

            pwm.out <= (DW'(cnt) < duty_act);
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: expected duty values are queued per stimulus step
// and compared against whole captured PWM periods.
module tb_pwm_generator;

    localparam int PER = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pwm_generator_if pwm_if ();

    pwm_generator #(
        .PERIOD          (PER),
        .DUTY_INIT       (5),
        .DUTY_STEP       (1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm   (pwm_if)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int model_duty = 5;
    int e_cnt = 0;
    int nper = 0;
    logic [PER-1:0] cur_vec = '0;
    logic [PER-1:0] last_period = '0;

    function automatic logic [PER-1:0] pat(input int d);
        logic [PER-1:0] p;
        p = '0;
        for (int i = 0; i < PER; i++) if (i < d) p[i] = 1'b1;
        return p;
    endfunction

    // Posedges since reset release; the period phase seen at a negedge is (e_cnt-1) mod PER.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_cnt <= 0;
        else        e_cnt <= e_cnt + 1;
    end

    // Every complete period must be one contiguous high run starting at cnt 0.
    always @(negedge clk) begin
        int ph;
        bit ok;
        if (rst_n && e_cnt > 0) begin
            ph = (e_cnt - 1) % PER;
            cur_vec[ph] = pwm_if.out;
            if (ph == PER - 1) begin
                ok = 1'b0;
                for (int k = 0; k <= PER; k++) if (cur_vec == pat(k)) ok = 1'b1;
                checks++;
                assert (ok) else begin
                    errors++;
                    $error("FAIL period_shape observed=%b required=contiguous_high_from_cnt0", cur_vec);
                end
                last_period = cur_vec;
                nper++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_periods(input int n, input string tag);
        int target;
        int c;
        target = nper + n;
        c = 0;
        while (nper < target && c < n * PER + 40) begin
            @(posedge clk);
            c++;
        end
        checks++;
        assert (nper >= target) else begin
            errors++;
            $error("FAIL %s_timeout observed=%0d required=%0d", tag, nper, target);
        end
    endtask

    task automatic expect_duty(input string tag, input int settle, input int n);
        int d;
        d = exp_q.pop_front();
        if (settle > 0) wait_periods(settle, tag);
        for (int i = 0; i < n; i++) begin
            wait_periods(1, tag);
            checks++;
            assert (last_period === pat(d)) else begin
                errors++;
                $error("FAIL %s observed=%b required=%b", tag, last_period, pat(d));
            end
        end
    endtask

    task automatic press(input bit inc, input bit dec, input int hold);
        @(negedge clk);
        pwm_if.increase_duty = inc;
        pwm_if.decrease_duty = dec;
        repeat (hold) @(negedge clk);
        pwm_if.increase_duty = 1'b0;
        pwm_if.decrease_duty = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic step(input bit inc, input bit dec, input int hold, input string tag, input int n);
        if (inc && !dec)      model_duty = (model_duty + 1 > PER) ? PER : model_duty + 1;
        else if (dec && !inc) model_duty = (model_duty - 1 < 0) ? 0 : model_duty - 1;
        exp_q.push_back(model_duty);
        press(inc, dec, hold);
        expect_duty(tag, 1, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        model_duty = 5;
    endtask

    initial begin
        int bp[6];
        int c;
        pwm_if.increase_duty = 1'b0;
        pwm_if.decrease_duty = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        assert (pwm_if.out === 1'b0) else begin
            errors++; $error("FAIL reset_out observed=%b required=0", pwm_if.out);
        end
        checks++;
        assert (pwm_if.inc_level === 1'b0 && pwm_if.dec_level === 1'b0) else begin
            errors++; $error("FAIL reset_levels observed=%b%b required=00", pwm_if.inc_level, pwm_if.dec_level);
        end
        #2 rst_n = 1'b1;

        // Idle: five whole periods at the reset duty, first one included.
        exp_q.push_back(5);
        expect_duty("idle_d5", 0, 5);

        step(1, 0, 10, "inc_to6", 1);
        step(1, 0, 10, "inc_to7", 1);
        step(1, 0, 10, "inc_to8", 2);
        step(0, 1, 10, "dec_to7", 1);
        step(0, 1, 10, "dec_to6", 1);
        step(0, 1, 10, "dec_to5", 2);

        // Saturation at both ends.
        do_reset();
        for (int i = 0; i < 7; i++)  step(1, 0, 10, "sat_inc", (i == 6) ? 3 : 1);
        for (int i = 0; i < 12; i++) step(0, 1, 10, "sat_dec", (i == 11) ? 3 : 1);

        // Glitches shorter than the debounce window and bouncing edges.
        do_reset();
        exp_q.push_back(model_duty);
        press(1, 0, 2);
        press(0, 1, 2);
        bp = '{1, 2, 3, 1, 2, 3};
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            pwm_if.increase_duty = (i % 2 == 0);
            repeat (bp[i]) @(negedge clk);
        end
        pwm_if.increase_duty = 1'b0;
        repeat (10) @(negedge clk);
        expect_duty("glitch_nochange", 1, 2);

        // Long hold gives exactly one step; the debounced level follows the pin.
        if (model_duty < PER) model_duty++;
        exp_q.push_back(model_duty);
        @(negedge clk);
        pwm_if.increase_duty = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        assert (pwm_if.inc_level === 1'b1) else begin
            errors++; $error("FAIL hold_level observed=%b required=1", pwm_if.inc_level);
        end
        repeat (100) @(negedge clk);
        pwm_if.increase_duty = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        assert (pwm_if.inc_level === 1'b0) else begin
            errors++; $error("FAIL release_level observed=%b required=0", pwm_if.inc_level);
        end
        expect_duty("hold200_one_step", 1, 2);

        step(1, 1, 10, "both_nochange", 2);
        step(1, 0, 10, "pre_rst_to7", 1);
        step(1, 0, 10, "pre_rst_to8", 1);

        // Mid-period reset while out is high.
        c = 0;
        @(negedge clk);
        while (e_cnt % PER != 3 && c < 2 * PER) begin
            @(negedge clk);
            c++;
        end
        checks++;
        assert (pwm_if.out === 1'b1) else begin
            errors++; $error("FAIL pre_reset_out observed=%b required=1", pwm_if.out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (pwm_if.out === 1'b0) else begin
            errors++; $error("FAIL async_reset_out observed=%b required=0", pwm_if.out);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        model_duty = 5;
        exp_q.push_back(5);
        expect_duty("post_reset_d5", 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
